uart_rx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//   Receive-side buffer and line-status controller for the 16550-style UART.
//   Takes each completed character from the RX deserializer and queues it with its error flags.
//   Drives RBR read data, the LSR receive bits (DR/OE/PE/FE/FIFOERR), and the RDA/CTI/RLS
//   interrupt sources to the register/interrupt block; supports 16550 FIFO and 16450 (1-deep) modes.
// PARAMETERS
//   DEPTH  16  FIFO entries in FIFO mode (power of 2)
//   AW     4   log2(DEPTH)
// PORTS
//   clk            in   1  system clock
//   rst            in   1  asynchronous reset, active high
//   baud_tick      in   1  one-cycle pulse per bit period
//   rx_data        in   8  received character, valid with rx_valid
//   rx_valid       in   1  one-cycle pulse: character complete
//   rx_frame_err   in   1  one-cycle pulse: stop/start bit error for current frame
//   rx_parity_err  in   1  one-cycle pulse: parity error for current frame
//   lcr            in   8  line control ([1:0] word len, [2] stop bits, [3] parity en)
//   fifo_en        in   1  FCR[0]: 1 = FIFO mode, 0 = 1-deep holding register
//   fifo_clr       in   1  FCR[1] write pulse: flush RX FIFO
//   fifo_trig      in   2  FCR[7:6] trigger level select
//   rd_en          in   1  host RBR read pulse (pop)
//   lsr_rd         in   1  host LSR read pulse
//   rd_data        out  8  head character; 8'h00 when empty
//   dr             out  1  data ready (count != 0)
//   oe             out  1  overrun error (sticky)
//   pe             out  1  parity error of head entry
//   fe             out  1  framing error of head entry
//   fifo_err       out  1  at least one queued entry carries PE or FE
//   count          out  AW+1  entries held
//   irq_rda        out  1  received-data-available interrupt source
//   irq_cti        out  1  character-timeout interrupt source
//   irq_rls        out  1  receiver-line-status interrupt source
// BEHAVIOUR
//   Reset: pointers, count, error counter, timeout counter, pending flags cleared; all outputs 0.
//   Entry = {pe, fe, data[7:0]}. rx_frame_err/rx_parity_err pulses set fe_pend/pe_pend.
//     Pending flags attach to the next written entry, then clear.
//     An error pulse in the same cycle as rx_valid attaches to that entry.
//   Capacity: DEPTH when fifo_en=1, else 1.
//   Write on rx_valid:
//     - not full: store; count+1.
//     - full, FIFO mode: character discarded, contents unchanged; oe<=1.
//     - full, 1-deep mode: entry overwritten; oe<=1.
//     - rx_valid and rd_en in the same cycle while full: pop and push both happen; no overrun.
//   Pop on rd_en with count>0: rd_ptr+1, count-1. rd_en while empty is ignored.
//   Latency: all state and outputs reflect an event from the clock edge after the pulse.
//   Pointers wrap modulo DEPTH.
//   fifo_err: err_cnt +1 on a push with pe|fe, -1 on a pop with pe|fe; fifo_err = (err_cnt != 0).
//   oe is cleared only by lsr_rd or reset.
//     Overrun and lsr_rd in the same cycle: oe stays 1.
//   pe/fe = head entry flags when count>0, else 0.
//   fifo_clr or any change of fifo_en: pointers, count, err_cnt, pending flags and timeout clear.
//     oe is not cleared by this flush.
//     This flush wins over a simultaneous rx_valid/rd_en; that character is dropped.
//   Trigger level: fifo_trig 00/01/10/11 -> 1/4/8/14.
//     irq_rda = fifo_en ? (count >= trig) : dr.
//   Char timeout (FIFO mode only):
//     frame_bits = 1 + (5+lcr[1:0]) + lcr[3] + (lcr[2] ? 2 : 1); limit = 4*frame_bits.
//     8-bit counter increments on baud_tick while count>0 and irq_cti=0.
//     Counter resets on push, pop, flush, or when count==0.
//     When the counter reaches limit: irq_cti<=1.
//     irq_cti clears on rd_en, rx_valid, flush, or fifo_en=0.
//   irq_rls = oe | pe | fe.
//   Reset asserted mid-operation: everything returns to reset values immediately; queued data lost.
// TESTING
//   1-deep mode: push 8'hA5 -> dr=1, irq_rda=1, rd_data=A5.
//     Push 8'h3C before any read -> rd_data=3C, oe=1.
//     Then lsr_rd -> oe=0.
//   FIFO mode, trig=10: push 7 chars -> irq_rda=0; 8th -> irq_rda=1, count=8.
//     8 pops -> data returned in order, dr=0.
//   FIFO fill:
//     17 pushes -> count=16, oe=1, 17th character absent.
//     Push+pop in the same cycle at full -> count stays 16, no new oe.
//   Error attach: rx_frame_err pulse, then push 8'h11 -> fe=1 at head, fifo_err=1, irq_rls=1.
//     Pop -> fe=0, fifo_err=0.
//   Timeout: lcr=8'h03 (8N1, frame_bits=10), push 1 char, no reads.
//     irq_cti rises after 40 baud_ticks, clears on rd_en.
//   Flush: 5 entries plus oe=1, pulse fifo_clr with a simultaneous rx_valid.
//     Result: count=0, dr=0, oe stays 1.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl_if.sv
// Host/deserializer-facing signal bundle for the UART receive FIFO controller.
// slave = the controller; master = whoever drives characters and host reads.
interface uart_rx_fifo_ctrl_if #(parameter int AW = 4);
  logic        baud_tick;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic        rx_parity_err;
  logic [7:0]  lcr;
  logic        fifo_en;
  logic        fifo_clr;
  logic [1:0]  fifo_trig;
  logic        rd_en;
  logic        lsr_rd;
  logic [7:0]  rd_data;
  logic        dr;
  logic        oe;
  logic        pe;
  logic        fe;
  logic        fifo_err;
  logic [AW:0] count;
  logic        irq_rda;
  logic        irq_cti;
  logic        irq_rls;

  modport slave (
    input  baud_tick, rx_data, rx_valid, rx_frame_err, rx_parity_err, lcr,
           fifo_en, fifo_clr, fifo_trig, rd_en, lsr_rd,
    output rd_data, dr, oe, pe, fe, fifo_err, count, irq_rda, irq_cti, irq_rls
  );

  modport master (
    output baud_tick, rx_data, rx_valid, rx_frame_err, rx_parity_err, lcr,
           fifo_en, fifo_clr, fifo_trig, rd_en, lsr_rd,
    input  rd_data, dr, oe, pe, fe, fifo_err, count, irq_rda, irq_cti, irq_rls
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// 16550-style receive FIFO with per-entry PE/FE flags, sticky overrun,
// trigger-level / char-timeout / line-status interrupt sources; 16- or 1-deep.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic                clk,
  input logic                rst,
  uart_rx_fifo_ctrl_if.slave bus
);
  localparam logic [AW:0] CAP_FIFO = (AW+1)'(DEPTH);

  typedef logic [9:0] entry_t;  // {pe, fe, data}

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, err_cnt_q, err_cnt_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          pe_pend_q, pe_pend_d, fe_pend_q, fe_pend_d;
  logic          oe_q, oe_d, cti_q, cti_d, fifo_en_q, fifo_en_d;

  entry_t      head, new_e;
  logic        has_data, full, flush, do_pop, do_push, wr_ok, overrun, ovwr;
  logic        new_err, head_err, tmo_inc;
  logic [AW:0] cap, trig;
  logic [7:0]  frame_bits, limit;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    has_data = (count_q != '0);
    cap      = bus.fifo_en ? CAP_FIFO : (AW+1)'(1);
    full     = (count_q >= cap);
    flush    = bus.fifo_clr | (bus.fifo_en != fifo_en_q);
    do_pop   = bus.rd_en & has_data & ~flush;
    wr_ok    = bus.rx_valid & ~flush;
    do_push  = wr_ok & (~full | do_pop);
    overrun  = wr_ok & full & ~do_pop;
    // 1-deep holding register replaces its only entry instead of dropping
    ovwr     = overrun & ~bus.fifo_en;
    new_e    = {pe_pend_q | bus.rx_parity_err, fe_pend_q | bus.rx_frame_err, bus.rx_data};
    new_err  = |new_e[9:8];
    head_err = |head[9:8];

    frame_bits = 8'd7 + 8'(bus.lcr[1:0]) + 8'(bus.lcr[3]) + 8'(bus.lcr[2]);
    limit      = {frame_bits[5:0], 2'b00};
    tmo_inc    = bus.fifo_en & bus.baud_tick & ~cti_q & has_data;

    case (bus.fifo_trig)
      2'b00:   trig = (AW+1)'(1);
      2'b01:   trig = (AW+1)'(4);
      2'b10:   trig = (AW+1)'(8);
      default: trig = (AW+1)'(14);
    endcase

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    pe_pend_d = pe_pend_q | bus.rx_parity_err;
    fe_pend_d = fe_pend_q | bus.rx_frame_err;
    fifo_en_d = bus.fifo_en;
    oe_d      = overrun ? 1'b1 : (bus.lsr_rd ? 1'b0 : oe_q);

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
      pe_pend_d = 1'b0;
      fe_pend_d = 1'b0;
    end else begin
      if (do_push || ovwr) begin
        pe_pend_d = 1'b0;
        fe_pend_d = 1'b0;
      end
      if (do_push) begin
        mem_d[wr_ptr_q] = new_e;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (ovwr) mem_d[rd_ptr_q] = new_e;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d   = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // an overwrite retires the old head's flags and adds the new entry's
      err_cnt_d = err_cnt_q + (AW+1)'((do_push | ovwr) & new_err)
                            - (AW+1)'((do_pop | ovwr) & head_err);
    end

    tmo_d = tmo_q;
    if (flush || do_push || do_pop || ovwr || !has_data) tmo_d = '0;
    else if (tmo_inc) tmo_d = tmo_q + 8'd1;

    cti_d = cti_q;
    if (flush || !bus.fifo_en || bus.rd_en || bus.rx_valid) cti_d = 1'b0;
    else if (tmo_inc && (tmo_q + 8'd1) >= limit) cti_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      tmo_q     <= '0;
      pe_pend_q <= 1'b0;
      fe_pend_q <= 1'b0;
      oe_q      <= 1'b0;
      cti_q     <= 1'b0;
      fifo_en_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      tmo_q     <= tmo_d;
      pe_pend_q <= pe_pend_d;
      fe_pend_q <= fe_pend_d;
      oe_q      <= oe_d;
      cti_q     <= cti_d;
      fifo_en_q <= fifo_en_d;
    end
  end

  assign bus.rd_data  = has_data ? head[7:0] : 8'h00;
  assign bus.dr       = has_data;
  assign bus.pe       = has_data & head[9];
  assign bus.fe       = has_data & head[8];
  assign bus.fifo_err = (err_cnt_q != '0);
  assign bus.count    = count_q;
  assign bus.oe       = oe_q;
  assign bus.irq_rda  = bus.fifo_en ? (count_q >= trig) : has_data;
  assign bus.irq_cti  = cti_q;
  assign bus.irq_rls  = oe_q | (has_data & (head[9] | head[8]));
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboarded bench for uart_rx_fifo_ctrl: directed 1-deep, FIFO, overrun,
// error-flag, timeout, flush and async-reset scenarios.
module tb_uart_rx_fifo_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_rx_fifo_ctrl_if #(.AW(4)) u_if();

  uart_rx_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // push one character; the model mirrors capacity / overwrite / discard rules
  task automatic push(input logic [7:0] d, input bit perr = 1'b0, input bit ferr = 1'b0);
    int cap;
    cap = u_if.fifo_en ? 16 : 1;
    u_if.rx_data       = d;
    u_if.rx_valid      = 1'b1;
    u_if.rx_parity_err = perr;
    u_if.rx_frame_err  = ferr;
    tick();
    u_if.rx_valid      = 1'b0;
    u_if.rx_parity_err = 1'b0;
    u_if.rx_frame_err  = 1'b0;
    if (sb.size() < cap) sb.push_back(d);
    else if (!u_if.fifo_en) sb[0] = d;
  endtask

  task automatic pop();
    if (sb.size() > 0) check("rd_data", {24'h0, u_if.rd_data}, {24'h0, sb.pop_front()});
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
  endtask

  task automatic lsr_read();
    u_if.lsr_rd = 1'b1;
    tick();
    u_if.lsr_rd = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    u_if.baud_tick = 0; u_if.rx_data = 0; u_if.rx_valid = 0; u_if.rx_frame_err = 0;
    u_if.rx_parity_err = 0; u_if.lcr = 8'h03; u_if.fifo_en = 0; u_if.fifo_clr = 0;
    u_if.fifo_trig = 2'b00; u_if.rd_en = 0; u_if.lsr_rd = 0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_count", 32'(u_if.count), 0);
    check("rst_flags", {u_if.dr, u_if.oe, u_if.pe, u_if.fe, u_if.fifo_err,
                        u_if.irq_rda, u_if.irq_cti, u_if.irq_rls}, 0);
    check("rst_rd_data", 32'(u_if.rd_data), 0);
    rst = 1'b0;
    repeat (2) tick();

    // 1-deep holding register
    push(8'hA5);
    check("hr_dr", 32'(u_if.dr), 1);
    check("hr_rda", 32'(u_if.irq_rda), 1);
    check("hr_data", 32'(u_if.rd_data), 32'(sb[0]));
    push(8'h3C);
    check("hr_ovwr_data", 32'(u_if.rd_data), 32'h3C);
    check("hr_oe", 32'(u_if.oe), 1);
    check("hr_count", 32'(u_if.count), 1);
    lsr_read();
    check("hr_oe_clr", 32'(u_if.oe), 0);
    pop();
    check("hr_dr_empty", 32'(u_if.dr), 0);

    // FIFO mode, trigger level 8
    u_if.fifo_en = 1'b1; u_if.fifo_trig = 2'b10;
    tick();
    sb.delete();
    for (int i = 0; i < 7; i++) push(8'($urandom));
    check("trig_below", 32'(u_if.irq_rda), 0);
    push(8'($urandom));
    check("trig_at", 32'(u_if.irq_rda), 1);
    check("trig_count", 32'(u_if.count), 8);
    for (int i = 0; i < 8; i++) pop();
    check("trig_dr_empty", 32'(u_if.dr), 0);
    check("trig_rda_empty", 32'(u_if.irq_rda), 0);

    // fill past capacity; 17th char must be discarded
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    check("fill_count", 32'(u_if.count), 16);
    check("fill_oe", 32'(u_if.oe), 1);
    lsr_read();
    check("fill_oe_clr", 32'(u_if.oe), 0);
    check("fill_head", 32'(u_if.rd_data), 32'h40);
    // simultaneous push and pop while full
    check("pp_rd_data", 32'(u_if.rd_data), 32'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(8'hEE);
    u_if.rx_data = 8'hEE; u_if.rx_valid = 1'b1; u_if.rd_en = 1'b1;
    tick();
    u_if.rx_valid = 1'b0; u_if.rd_en = 1'b0;
    check("pp_count", 32'(u_if.count), 16);
    check("pp_no_oe", 32'(u_if.oe), 0);
    for (int i = 0; i < 16; i++) pop();
    check("drain_count", 32'(u_if.count), 0);

    // error flag attachment
    u_if.rx_frame_err = 1'b1;
    tick();
    u_if.rx_frame_err = 1'b0;
    push(8'h11);
    check("err_fe", 32'(u_if.fe), 1);
    check("err_pe", 32'(u_if.pe), 0);
    check("err_fifo_err", 32'(u_if.fifo_err), 1);
    check("err_rls", 32'(u_if.irq_rls), 1);
    pop();
    check("err_fe_clr", 32'(u_if.fe), 0);
    check("err_fifo_err_clr", 32'(u_if.fifo_err), 0);
    push(8'h22, 1'b1, 1'b0);
    push(8'h33);
    check("perr_same_cycle", 32'(u_if.pe), 1);
    pop();
    check("perr_next_clean", {u_if.pe, u_if.fe, u_if.fifo_err}, 0);
    pop();

    // character timeout, 8N1 -> 40 baud ticks
    u_if.lcr = 8'h03;
    push(8'h5A);
    for (int i = 0; i < 39; i++) begin
      u_if.baud_tick = 1'b1; tick(); u_if.baud_tick = 1'b0;
    end
    check("cti_before", 32'(u_if.irq_cti), 0);
    u_if.baud_tick = 1'b1; tick(); u_if.baud_tick = 1'b0;
    check("cti_at_limit", 32'(u_if.irq_cti), 1);
    pop();
    check("cti_clr", 32'(u_if.irq_cti), 0);

    // flush with a simultaneous character; oe survives
    for (int i = 0; i < 17; i++) push(8'($urandom));
    for (int i = 0; i < 11; i++) pop();
    check("flush_pre_count", 32'(u_if.count), 5);
    check("flush_pre_oe", 32'(u_if.oe), 1);
    u_if.fifo_clr = 1'b1; u_if.rx_valid = 1'b1; u_if.rx_data = 8'h77;
    tick();
    u_if.fifo_clr = 1'b0; u_if.rx_valid = 1'b0;
    sb.delete();
    check("flush_count", 32'(u_if.count), 0);
    check("flush_dr", 32'(u_if.dr), 0);
    check("flush_oe", 32'(u_if.oe), 1);
    check("flush_rd_data", 32'(u_if.rd_data), 0);
    lsr_read();

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push(8'($urandom));
    check("pre_rst_count", 32'(u_if.count), 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(u_if.count), 0);
    check("async_rst_dr", 32'(u_if.dr), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    d = 8'hC3;
    push(d);
    check("post_rst_data", 32'(u_if.rd_data), 32'(d));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
